// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding, NOP word and default geometry for the instruction memory block
package imem_pkg;
  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_LOAD_BASE = 1;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: single-port synchronous RAM, 1-cycle read, write-enable; rdata holds when not read
module imem_ram #(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/imem_load_fetch_ctrl.sv
// imem_load_fetch_ctrl: clears the instruction RAM, loads a program image word-serially,
// then hands the RAM to the CPU fetch path; the CPU is stalled until then.
module imem_load_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LOAD_BASE = DEF_LOAD_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic              reload,
  input  logic              fetch_req,
  input  logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              cpu_stall,
  output logic [ADDR_W:0]   load_count,
  output logic              load_ovf,
  output logic              err_misalign,
  output logic              err_range
);
  state_t state, state_n;
  logic [ADDR_W-1:0] clr_cnt, ld_addr, fetch_idx, ram_addr;
  logic [31:0] ram_wdata, ram_rdata, instr_hold;
  logic hs, fetch, reload_go, misalign, out_range, at_top, ram_en, ram_we, bad_q;
  assign ld_ready = state == LOAD;
  assign cpu_stall = state != RUN;
  assign hs = ld_valid & ld_ready;
  assign fetch = fetch_req & ~cpu_stall;
  assign reload_go = reload & ~cpu_stall;
  assign misalign = pc[1:0] != 2'b00;
  assign out_range = pc[31:2] >= 30'(DEPTH);
  assign fetch_idx = pc[ADDR_W+1:2];
  assign ld_addr = ADDR_W'(LOAD_BASE) + load_count[ADDR_W-1:0];
  assign at_top = ld_addr == ADDR_W'(DEPTH - 1);
  // bad fetches never touch the RAM, so the NOP substitution happens here
  assign instr = instr_valid ? (bad_q ? NOP : ram_rdata) : instr_hold;
  always_comb begin
    state_n = state;
    ram_en = 1'b0;
    ram_we = 1'b0;
    ram_addr = clr_cnt;
    ram_wdata = NOP;
    case (state)
      CLEAR: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        if (clr_cnt == ADDR_W'(DEPTH - 1)) state_n = LOAD;
      end
      LOAD: begin
        ram_en = hs;
        ram_we = 1'b1;
        ram_addr = ld_addr;
        ram_wdata = ld_data;
        if (hs & (ld_last | at_top)) state_n = RUN;
      end
      default: begin
        ram_en = fetch & ~misalign & ~out_range;
        ram_addr = fetch_idx;
        if (reload) state_n = CLEAR;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CLEAR;
      clr_cnt <= '0;
      load_count <= '0;
      load_ovf <= 1'b0;
      err_misalign <= 1'b0;
      err_range <= 1'b0;
      instr_valid <= 1'b0;
      bad_q <= 1'b0;
      instr_hold <= NOP;
    end else begin
      state <= state_n;
      clr_cnt <= state == CLEAR ? clr_cnt + 1'b1 : '0;
      load_count <= reload_go ? '0 : hs ? load_count + 1'b1 : load_count;
      load_ovf <= ~reload_go & (load_ovf | (hs & ~ld_last & at_top));
      err_misalign <= ~reload_go & (err_misalign | (fetch & misalign));
      err_range <= ~reload_go & (err_range | (fetch & out_range));
      instr_valid <= fetch;
      bad_q <= fetch & (misalign | out_range);
      if (instr_valid) instr_hold <= instr;
    end
  imem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .en(ram_en),
    .we(ram_we),
    .addr(ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// tb_imem_load_fetch_ctrl: directed clear/load/fetch sequence with a fetch scoreboard
module tb_imem_load_fetch_ctrl;
  logic clk = 1'b0, reset, ld_valid, ld_ready, ld_last, reload, fetch_req;
  logic instr_valid, cpu_stall, load_ovf, err_misalign, err_range;
  logic [31:0] ld_data, pc, instr;
  logic [6:0] load_count;
  logic [31:0] mem_model [64];
  logic [31:0] exp_q [$];
  logic [31:0] last_exp;
  int tests = 0, fails = 0, lc_model = 0;

  imem_load_fetch_ctrl dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .reload(reload), .fetch_req(fetch_req), .pc(pc), .instr(instr),
    .instr_valid(instr_valid), .cpu_stall(cpu_stall), .load_count(load_count),
    .load_ovf(load_ovf), .err_misalign(err_misalign), .err_range(err_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    return (a[1:0] != 2'b00 || a[31:2] >= 30'd64) ? 32'h0 : mem_model[a[7:2]];
  endfunction

  task automatic model_clear();
    foreach (mem_model[i]) mem_model[i] = 32'h0;
    lc_model = 0;
  endtask

  task automatic check_out();
    if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      chk("instr_valid", instr_valid, 1'b1);
      chk("instr", instr, last_exp);
    end else begin
      chk("valid_idle", instr_valid, 1'b0);
      chk("instr_hold", instr, last_exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_out();
  endtask

  task automatic drive_fetch(input logic [31:0] a);
    fetch_req = 1'b1;
    pc = a;
    exp_q.push_back(exp_instr(a));
  endtask

  task automatic fetch(input logic [31:0] a);
    drive_fetch(a);
    cyc();
    fetch_req = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_ld_ready", ld_ready, 1'b0);
    chk("rst_stall", cpu_stall, 1'b1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_count", load_count, 7'd0);
    chk("rst_flags", {load_ovf, err_misalign, err_range}, 3'b000);
  endtask

  // the k-th negedge after entering CLEAR sees LOAD only when k reaches 64
  task automatic wait_clear();
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk("clr_ready", ld_ready, k == 64);
      chk("clr_stall", cpu_stall, 1'b1);
      chk("clr_valid", instr_valid, 1'b0);
    end
  endtask

  task automatic load_words(input int n, input logic last_on_final, input logic [31:0] seed);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data = seed ^ (i * 32'h0001_1111);
      ld_last = last_on_final && i == n - 1;
      mem_model[1 + lc_model] = ld_data;
      lc_model++;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ld_valid = 0; ld_last = 0; ld_data = 0; reload = 0; fetch_req = 0; pc = 0;
    last_exp = 32'h0;
    model_clear();
    #23;
    check_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    wait_clear();
    load_words(3, 1'b0, 32'h0273_4820);
    @(negedge clk);
    chk("idle_count", load_count, 7'd3);
    chk("idle_ready", ld_ready, 1'b1);
    load_words(3, 1'b0, 32'hA5A5_0003);
    chk("pre_last_stall", cpu_stall, 1'b1);
    load_words(1, 1'b1, 32'h1234_5678);
    chk("load7_count", load_count, 7'd7);
    chk("load7_stall", cpu_stall, 1'b0);
    chk("load7_ready", ld_ready, 1'b0);
    fetch(32'd4);
    fetch(32'd0);
    cyc();
    for (int i = 1; i <= 7; i++) begin
      drive_fetch(32'(i * 4));
      cyc();
    end
    fetch_req = 1'b0;
    cyc();
    fetch(32'd6);
    chk("misalign_set", err_misalign, 1'b1);
    chk("range_clear", err_range, 1'b0);
    fetch(32'd256);
    chk("range_set", err_range, 1'b1);
    chk("misalign_sticky", err_misalign, 1'b1);
    cyc();
    chk("flags_hold", {err_misalign, err_range}, 2'b11);
    reload = 1'b1;
    drive_fetch(32'd8);
    cyc();
    reload = 1'b0;
    fetch_req = 1'b0;
    chk("reload_stall", cpu_stall, 1'b1);
    chk("reload_flags", {load_ovf, err_misalign, err_range}, 3'b000);
    chk("reload_count", load_count, 7'd0);
    model_clear();
    fetch_req = 1'b1;
    pc = 32'd6;
    wait_clear();
    fetch_req = 1'b0;
    chk("clr_fetch_noflag", err_misalign, 1'b0);
    load_words(1, 1'b1, 32'hDEAD_BEEF);
    chk("reload1_count", load_count, 7'd1);
    fetch(32'd8);
    fetch(32'd4);
    reload = 1'b1;
    cyc();
    reload = 1'b0;
    model_clear();
    wait_clear();
    load_words(62, 1'b0, 32'h5000_0000);
    chk("ovf_pre", load_ovf, 1'b0);
    chk("ovf_pre_ready", ld_ready, 1'b1);
    chk("ovf_pre_count", load_count, 7'd62);
    load_words(1, 1'b0, 32'h7777_0063);
    chk("ovf_set", load_ovf, 1'b1);
    chk("ovf_ready", ld_ready, 1'b0);
    chk("ovf_stall", cpu_stall, 1'b0);
    chk("ovf_count", load_count, 7'd63);
    fetch(32'd252);
    fetch(32'd8);
    reload = 1'b1;
    cyc();
    reload = 1'b0;
    model_clear();
    wait_clear();
    load_words(3, 1'b0, 32'hCAFE_0000);
    reset = 1'b1;
    #1;
    check_reset_vals();
    last_exp = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    wait_clear();
    load_words(2, 1'b1, 32'hBEEF_0001);
    chk("reset_reload_count", load_count, 7'd2);
    chk("reset_reload_stall", cpu_stall, 1'b0);
    fetch(32'd12);
    fetch(32'd16);
    fetch(32'd8);
    cyc();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_load_fetch_ctrl.md
# imem_load_fetch_ctrl

Sequencer and arbiter for the single-cycle core's instruction memory. It owns a single-port instruction RAM and shares it between a word-serial program loader and the CPU fetch path. After reset it clears the RAM, then accepts a program image, then hands the RAM to fetch. The CPU is stalled until the RAM belongs to fetch.

## Interface
- DEPTH, 64, number of 32-bit instruction words.
- ADDR_W, 6, word-index width; must equal clog2(DEPTH).
- LOAD_BASE, 1, word index of the first loaded word (byte address 4).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- ld_valid  in  1  loader word available.
- ld_ready  out  1  controller accepts loader word.
- ld_data  in  32  instruction word.
- ld_last  in  1  marks the final word of the image; qualified by the handshake.
- reload  in  1  single-cycle request to re-enter clear/load; honoured only in RUN.
- fetch_req  in  1  CPU fetch request.
- pc  in  32  fetch byte address.
- instr  out  32  fetched instruction.
- instr_valid  out  1  instr valid this cycle.
- cpu_stall  out  1  high whenever the state is not RUN.
- load_count  out  ADDR_W+1  words accepted in the current load.
- load_ovf  out  1  sticky: the image reached the top of RAM without ld_last.
- err_misalign  out  1  sticky: fetch with pc[1:0] != 0.
- err_range  out  1  sticky: fetch with word index >= DEPTH.

## Operation
- States: CLEAR, LOAD, RUN.
- Reset state is CLEAR, with these output values:
  - ld_ready=0, cpu_stall=1, instr=0, instr_valid=0.
  - load_count=0, all sticky flags 0.
- CLEAR:
  - Writes 32'h0 to word 0..DEPTH-1, one word per cycle, from an internal counter.
  - Moves to LOAD after writing word DEPTH-1.
  - Entering CLEAR zeroes load_count, load_ovf, err_misalign and err_range.
- LOAD:
  - ld_ready=1.
  - Handshake is ld_valid & ld_ready.
  - Each handshake writes ld_data to word LOAD_BASE+load_count and increments load_count.
  - A handshake with ld_last moves to RUN.
  - A handshake writing word DEPTH-1 without ld_last sets load_ovf and moves to RUN.
  - ld_valid low: the controller waits indefinitely.
- RUN:
  - ld_ready=0, cpu_stall=0.
  - On fetch_req, word index = pc[ADDR_W+1:2], and the RAM is read.
  - Misaligned or out-of-range pc: set the matching sticky flag, return instr=0 (NOP), and do not read RAM.
  - reload moves to CLEAR on the next edge.
- fetch_req outside RUN is ignored: no instr_valid and no flags.
- Simultaneous reload and fetch_req in RUN: the fetch is accepted and completes with instr_valid on the next cycle; the state goes to CLEAR at the same time.
- A reset asserted mid-CLEAR or mid-LOAD aborts the operation immediately. The sequence then restarts in CLEAR, and the partial image is discarded.

## Timing
- CLEAR lasts exactly DEPTH cycles, from the first edge after reset deasserts to the first LOAD cycle.
- Loader throughput is 1 word/cycle. ld_ready is registered and depends only on state.
- RUN is entered on the edge of the final handshake; cpu_stall falls in that same cycle.
- Fetch latency is 1 cycle: fetch_req at edge N gives instr and instr_valid during cycle N+1.
- Back-to-back fetches run one per cycle.
- instr holds its value while instr_valid=0; instr_valid is a single-cycle pulse per request.
- Sticky flags assert in the cycle after the offending fetch_req.

## Structure
- Shared package imem_pkg holds:
  - the state enum (CLEAR/LOAD/RUN);
  - the NOP constant 32'h0000_0000;
  - the default DEPTH/ADDR_W/LOAD_BASE.
- One sub-module: imem_ram, a single-port synchronous RAM with 1-cycle read and write-enable, DEPTH x 32.
- The controller drives the imem_ram port through a mux:
  - clear counter in CLEAR;
  - load address in LOAD;
  - fetch index in RUN.

## Test plan
- Reset, then idle loader for 64 cycles: cpu_stall=1, ld_ready=0 throughout CLEAR, ld_ready=1 at cycle 64. Then load 7 words with ld_last on the 7th: load_count=7, RUN entered, cpu_stall=0.
- After loading 32'h0273_4820 at LOAD_BASE, fetch_req with pc=4: instr=32'h0273_4820 and instr_valid=1 the next cycle. Fetch pc=0 returns 0.
- Fetch pc=6: instr=0, err_misalign=1. Fetch pc=256: instr=0, err_range=1. Both flags stay set until reload.
- Load 63 words without ld_last: load_ovf=1 after the 63rd handshake, RUN entered, ld_ready=0.
- In RUN, assert reload and fetch_req together: instr_valid pulses next cycle and cpu_stall=1 with the state in CLEAR. After 64 cycles, fetch of the previous address returns 0 until reloaded.
- Assert reset after 3 loaded words: all outputs return to reset values. A fresh clear+load of 2 words gives load_count=2, and the old words 3..4 read 0.
